// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared single-precision constants, flag indices and divider state type
package fp32_pkg;

  localparam int EXP_BITS = 8;
  localparam int MAN_BITS = 23;
  localparam int BIAS     = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  // one quotient bit per cycle: hidden bit, MAN_BITS fraction bits, two for normalise and guard, one sticky
  localparam int ITER_N = MAN_BITS + 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIFY,
    S_ITER,
    S_ROUND
  } div_state_t;

endpackage

// File: rtl/fp_div_classify.sv
// rtl/fp_div_classify.sv - combinational operand classifier and special-case result generator for divide
module fp_div_classify
  import fp32_pkg::*;
#(
  parameter int EXP_W = EXP_BITS,
  parameter int MAN_W = MAN_BITS
) (
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 is_special,
  output logic [EXP_W+MAN_W:0] special_result,
  output logic [3:0]           special_flags
);

  localparam int W = EXP_W + MAN_W + 1;

  logic sign;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic a_emax, b_emax;
  logic [W-1:0] inf_val;
  logic [W-1:0] zero_val;

  // denormals are flushed: any zero exponent counts as zero regardless of mantissa
  assign a_emax = (in1[W-2 -: EXP_W] == EXP_W'(EXP_MAX));
  assign b_emax = (in2[W-2 -: EXP_W] == EXP_W'(EXP_MAX));
  assign a_zero = (in1[W-2 -: EXP_W] == '0);
  assign b_zero = (in2[W-2 -: EXP_W] == '0);
  assign a_inf  = a_emax & ~(|in1[MAN_W-1:0]);
  assign b_inf  = b_emax & ~(|in2[MAN_W-1:0]);
  assign a_nan  = a_emax & (|in1[MAN_W-1:0]);
  assign b_nan  = b_emax & (|in2[MAN_W-1:0]);

  assign sign     = in1[W-1] ^ in2[W-1];
  assign inf_val  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_val = {sign, {(W-1){1'b0}}};

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    special_flags  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      is_special             = 1'b1;
      special_result         = W'(QNAN);
      special_flags[FLG_INV] = 1'b1;
    end else if (a_inf) begin
      is_special     = 1'b1;
      special_result = inf_val;
    end else if (b_zero) begin
      is_special            = 1'b1;
      special_result        = inf_val;
      special_flags[FLG_DZ] = 1'b1;
    end else if (a_zero || b_inf) begin
      is_special     = 1'b1;
      special_result = zero_val;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential single-precision divider: restoring radix-2 mantissa divide with RNE rounding
module fp_div_seq
  import fp32_pkg::*;
#(
  parameter int EXP_W = EXP_BITS,
  parameter int MAN_W = MAN_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] final_val,
  output logic [3:0]           flags
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int R_W = MAN_W + 2;
  localparam int Q_W = MAN_W + 4;
  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EMAX_S = E_W'(EXP_MAX);
  localparam logic signed [E_W-1:0] ONE_S  = E_W'(1);
  localparam logic signed [E_W-1:0] ZERO_S = '0;
  localparam logic [4:0] CNT_LAST = 5'(ITER_N - 1);

  div_state_t state_q, state_d;

  logic [W-1:0]          a_q, b_q;
  logic                  sign_q;
  logic signed [E_W-1:0] exp_q;
  logic [R_W-1:0]        rem_q;
  logic [MAN_W:0]        div_q;
  logic [Q_W-1:0]        quo_q;
  logic [4:0]            cnt_q;

  logic         is_special;
  logic [W-1:0] special_result;
  logic [3:0]   special_flags;

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .in1            (a_q),
    .in2            (b_q),
    .is_special     (is_special),
    .special_result (special_result),
    .special_flags  (special_flags)
  );

  // restoring step: remainder stays below 2*divisor, so the shifted value always fits R_W bits
  logic           rem_ge;
  logic [R_W-1:0] rem_sub;
  assign rem_ge  = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  logic [MAN_W-1:0]      frac_pre;
  logic                  guard, sticky, round_up;
  logic signed [E_W-1:0] exp_n, exp_r;
  logic [MAN_W:0]        frac_sum;
  logic [W-1:0]          round_result;
  logic [3:0]            round_flags;

  always_comb begin
    if (quo_q[Q_W-1]) begin
      frac_pre = quo_q[Q_W-2:3];
      guard    = quo_q[2];
      sticky   = (|quo_q[1:0]) | (|rem_q);
      exp_n    = exp_q;
    end else begin
      frac_pre = quo_q[Q_W-3:2];
      guard    = quo_q[1];
      sticky   = quo_q[0] | (|rem_q);
      exp_n    = exp_q - ONE_S;
    end
    round_up = guard & (sticky | frac_pre[0]);
    // carry out of the fraction leaves it all-zero, which is exactly 1.0 at the next exponent
    frac_sum = {1'b0, frac_pre} + (MAN_W+1)'(round_up);
    exp_r    = frac_sum[MAN_W] ? (exp_n + ONE_S) : exp_n;

    round_flags  = '0;
    round_result = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    if (exp_r >= EMAX_S) begin
      round_result         = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags[FLG_OVF] = 1'b1;
    end else if (exp_r <= ZERO_S) begin
      round_result         = {sign_q, {(W-1){1'b0}}};
      round_flags[FLG_UNF] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = is_special ? S_IDLE : S_ITER;
      S_ITER:     if (cnt_q == CNT_LAST) state_d = S_ROUND;
      S_ROUND:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      final_val <= '0;
      flags     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          a_q    <= in1;
          b_q    <= in2;
          sign_q <= in1[W-1] ^ in2[W-1];
          exp_q  <= $signed({2'b00, in1[W-2 -: EXP_W]}) - $signed({2'b00, in2[W-2 -: EXP_W]}) + BIAS_S;
          busy   <= 1'b1;
        end
        S_CLASSIFY: begin
          if (is_special) begin
            final_val <= special_result;
            flags     <= special_flags;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            rem_q <= {2'b01, a_q[MAN_W-1:0]};
            div_q <= {1'b1, b_q[MAN_W-1:0]};
            quo_q <= '0;
            cnt_q <= '0;
          end
        end
        S_ITER: begin
          quo_q <= {quo_q[Q_W-2:0], rem_ge};
          rem_q <= {rem_sub[R_W-2:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        S_ROUND: begin
          final_val <= round_result;
          flags     <= round_flags;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for the sequential FP divider
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] final_val;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .final_val (final_val),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // called #1 after a rising edge; returns #1 after the edge where done was seen
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [3:0] flg,
                       output int lat, output bit busy_ok);
    start = 1'b1; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = busy;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    if (!done) lat = 999;
    res = final_val;
    flg = flags;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (final_val !== 32'h0) begin n_fail++; $display("FAIL reset_final got %h want 0", final_val); end
    n_checks++; if (flags !== 4'h0)      begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags); end
  endtask

  task automatic test_normal();
    logic [31:0] a_v [3] = '{32'h3FC00000, 32'h3F800000, 32'hC0C00000};
    logic [31:0] b_v [3] = '{32'h3F000000, 32'h40400000, 32'h40000000};
    logic [31:0] q_v [3] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000};
    logic [31:0] res; logic [3:0] flg; int lat; bit bok;
    for (int i = 0; i < 3; i++) begin
      do_op(a_v[i], b_v[i], res, flg, lat, bok);
      n_checks++; if (res !== q_v[i]) begin n_fail++; $display("FAIL normal%0d_result got %h want %h", i, res, q_v[i]); end
      n_checks++; if (flg !== 4'h0)   begin n_fail++; $display("FAIL normal%0d_flags got %b want 0000", i, flg); end
      n_checks++; if (lat !== 29)     begin n_fail++; $display("FAIL normal%0d_latency got %0d want 29", i, lat); end
      n_checks++; if (bok !== 1'b1)   begin n_fail++; $display("FAIL normal%0d_busy got %b want 1", i, bok); end
      n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL normal%0d_busy_at_done got %b want 0", i, busy); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL normal%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_specials_and_range();
    logic [31:0] a_v [5] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] b_v [5] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h00800000, 32'h7F000000};
    logic [31:0] q_v [5] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    logic [3:0]  f_v [5] = '{4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0001};
    int          l_v [5] = '{1, 1, 1, 29, 29};
    logic [31:0] res; logic [3:0] flg; int lat; bit bok;
    for (int i = 0; i < 5; i++) begin
      do_op(a_v[i], b_v[i], res, flg, lat, bok);
      n_checks++; if (res !== q_v[i]) begin n_fail++; $display("FAIL edge%0d_result got %h want %h", i, res, q_v[i]); end
      n_checks++; if (flg !== f_v[i]) begin n_fail++; $display("FAIL edge%0d_flags got %b want %b", i, flg, f_v[i]); end
      n_checks++; if (lat !== l_v[i]) begin n_fail++; $display("FAIL edge%0d_latency got %0d want %0d", i, lat, l_v[i]); end
    end
  endtask

  task automatic test_restart_ignored();
    int lat = 0; int extra = 0;
    start = 1'b1; in1 = 32'h3F800000; in2 = 32'h40400000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 6);
      if (lat == 6) begin in1 = 32'h40000000; in2 = 32'h3F800000; end
      if (done) break;
    end
    start = 1'b0;
    n_checks++; if (lat !== 29)              begin n_fail++; $display("FAIL restart_latency got %0d want 29", lat); end
    n_checks++; if (final_val !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL restart_result got %h want 3eaaaaab", final_val); end
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_checks++; if (extra !== 0)             begin n_fail++; $display("FAIL restart_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [3:0] flg; int lat; bit bok;
    do_op(32'hC0C00000, 32'h40000000, res, flg, lat, bok);
    n_checks++; if (res !== 32'hC0400000) begin n_fail++; $display("FAIL b2b_first got %h want c0400000", res); end
    n_checks++; if (done !== 1'b1)        begin n_fail++; $display("FAIL b2b_done_high got %b want 1", done); end
    do_op(32'h3FC00000, 32'h3F000000, res, flg, lat, bok);
    n_checks++; if (res !== 32'h40400000) begin n_fail++; $display("FAIL b2b_second got %h want 40400000", res); end
    n_checks++; if (lat !== 29)           begin n_fail++; $display("FAIL b2b_latency got %0d want 29", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [3:0] flg; int lat; bit bok; int seen = 0;
    start = 1'b1; in1 = 32'h3F800000; in2 = 32'h40400000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_checks++; if (final_val !== 0)  begin n_fail++; $display("FAIL mid_final got %h want 0", final_val); end
    n_checks++; if (flags !== 4'h0)   begin n_fail++; $display("FAIL mid_flags got %b want 0000", flags); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++; if (seen !== 0)       begin n_fail++; $display("FAIL mid_no_done got %0d want 0", seen); end
    do_op(32'h3FC00000, 32'h3F000000, res, flg, lat, bok);
    n_checks++; if (res !== 32'h40400000) begin n_fail++; $display("FAIL mid_after got %h want 40400000", res); end
    n_checks++; if (lat !== 29)       begin n_fail++; $display("FAIL mid_after_latency got %0d want 29", lat); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_normal();
    test_specials_and_range();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Multi-cycle IEEE-754 single-precision divider controller.
- Captures two operands on a start pulse and resolves special cases in one cycle.
- Otherwise it sequences a radix-2 restoring mantissa division (one quotient bit per cycle), then normalises and rounds to nearest-even.
- Sits beside the combinational FP arithmetic units as the area-cheap, correctly-rounded divide path. It has a start/busy/done handshake toward the issuing control logic.

Parameters:
- EXP_W, 8, exponent field width; only the default is verified.
- MAN_W, 23, stored mantissa width; iteration count is MAN_W+4 = 27.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request pulse; sampled only in IDLE
- in1  input  32  dividend, IEEE-754 single
- in2  input  32  divisor, IEEE-754 single
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; final and flags are valid from this cycle on
- final  output  32  quotient; held until the next done
- flags  output  4  {invalid, div_by_zero, overflow, underflow}; held with final

Behaviour:
- Reset: clk single clock; reset is asynchronous and active-high (rst). While rst is high: state=IDLE, busy=0, done=0, final=0, flags=0, all internal registers cleared.
- Reset mid-operation: the operation is abandoned with no done. The first start after rst falls is accepted normally.
- States: IDLE, CLASSIFY, ITER, ROUND.
- IDLE:
  - start=1 (edge E0) latches in1/in2, sign=in1[31]^in2[31], and exp_diff = E1-E2+127 as 10-bit signed. Goes to CLASSIFY; busy=1.
  - start while busy is ignored and not queued.
- Operand classification:
  - exponent 0 → zero; denormals are flushed to zero, mantissa ignored.
  - exponent 255, mantissa 0 → inf.
  - exponent 255, mantissa ≠0 → NaN.
- CLASSIFY (edge E1), special cases. Result is written, done=1, busy=0, return to IDLE; specials therefore complete 1 edge after E0.
  - NaN input, 0/0, or inf/inf → 0x7FC00000, invalid=1.
  - finite-nonzero/0 → signed inf, div_by_zero=1.
  - inf/finite → signed inf, no flag.
  - 0/nonzero or finite/inf → signed zero, no flag.
- CLASSIFY, normal case: R = {1'b0, 1, man1} (25 bits), D = {1, man2}, q=0, cnt=0 → ITER.
- ITER (27 edges, E2..E28), each edge:
  - if R>=D then q bit=1 and R=R-D, else q bit=0;
  - q shifts in at the LSB, R <<= 1, cnt++.
  - Leave for ROUND when cnt reaches 26 on the current edge.
  - Resulting q[26] has weight 2^0.
- ROUND (edge E29):
  - If q[26]=1: mant=q[26:3], guard=q[2], sticky=|q[1:0] | (R≠0).
  - Else: mant=q[25:2], guard=q[1], sticky=q[0] | (R≠0), exp_diff -= 1.
  - Round-to-nearest-even: increment when guard & (sticky | mant[0]). A mantissa carry-out gives mant=0x800000 and exp+1.
  - exp ≥ 255 → signed inf, overflow=1.
  - exp ≤ 0 → signed zero, underflow=1.
  - else final = {sign, exp[7:0], mant[22:0]}.
  - done=1, busy=0, → IDLE.
- Latency: normal path, done rises 29 edges after E0; special path, 1 edge after E0.
- done is a single cycle. A start asserted in the same cycle done is high is accepted, because the state is already IDLE.
- flags are replaced (not accumulated) on every done.

Decomposition:
- Package fp32_pkg holds:
  - constants BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000;
  - field widths;
  - flag bit indices FLG_INV=3, FLG_DZ=2, FLG_OVF=1, FLG_UNF=0;
  - state enum;
  - iteration count constant.
- One sub-module, fp_div_classify: combinational operand classifier and special-result generator (inputs in1, in2; outputs is_special, special_result, special_flags). It is reusable by other FP units.
- The FSM, restoring-divide datapath and rounding stay in fp_div_seq.

Test Plan:
- 0x3FC00000 / 0x3F000000 (1.5/0.5) → final=0x40400000, flags=0, done exactly 29 edges after the start edge, busy high throughout.
- 0x3F800000 / 0x40400000 (1/3) → final=0x3EAAAAAB (round-up path), flags=0. Also 0xC0C00000 / 0x40000000 → 0xC0400000.
- Specials, each with done 1 edge after start:
  - 0x3F800000 / 0x00000000 → 0x7F800000, flags=0100;
  - 0x00000000 / 0x00000000 → 0x7FC00000, flags=1000;
  - 0x7F800000 / 0x7F800000 → 0x7FC00000, flags=1000.
- Range:
  - 0x7F000000 / 0x00800000 → 0x7F800000, flags=0010;
  - 0x00800000 / 0x7F000000 → 0x00000000, flags=0001.
- Handshake: start re-pulsed at ITER cycle 5 is ignored (single done, result of the first operands). A start coincident with done is accepted and yields a second done 29 edges later.
- Reset mid-operation: rst asserted asynchronously at ITER cycle 10 → busy/done/final/flags drop to 0 immediately, no done. The next start with 1.5/0.5 returns 0x40400000.
